// File: rtl/shifter_32_pkg.sv
// Shared constants for the 32-bit barrel shifter: data/shift widths and direction encoding.
package shifter_32_pkg;

  localparam int WIDTH = 32;
  localparam int SA_W  = $clog2(WIDTH);

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shifter_32_core.sv
// Combinational log2 barrel shifter: one right-shifting datapath, left shifts via bit reversal.
// No state and no flow control; the result is valid whenever the inputs are.
module shifter_32_core
  import shifter_32_pkg::*;
(
  input  logic [WIDTH-1:0] X,
  input  logic [SA_W-1:0]  Sa,
  input  logic             Arith,
  input  logic             Right,
  output logic [WIDTH-1:0] Y
);

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  logic             fill;
  logic [WIDTH-1:0] stage;
  logic [WIDTH-1:0] fill_mask;

  // Left shifts never sign-fill, so fill collapses to 0 for them.
  assign fill = Arith & (Right == DIR_RIGHT) & X[WIDTH-1];

  always_comb begin
    stage     = (Right == DIR_RIGHT) ? X : bit_rev(X);
    fill_mask = '0;
    // Stages run from the largest amount (WIDTH/2) down to 1, each selected by one Sa bit.
    for (int i = SA_W - 1; i >= 0; i--) begin
      fill_mask = fill ? ~({WIDTH{1'b1}} >> (1 << i)) : '0;
      if (Sa[i]) stage = (stage >> (1 << i)) | fill_mask;
    end
    Y = (Right == DIR_RIGHT) ? stage : bit_rev(stage);
  end

endmodule

// File: rtl/shifter_32.sv
// Registered 32-bit barrel shifter: 1-cycle latency, one op per cycle, no backpressure.
// Sh holds its last value when idle; out_valid marks cycles carrying a fresh result.
module shifter_32
  import shifter_32_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [SA_W-1:0]  Sa,
  input  logic             Arith,
  input  logic             Right,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sh,
  output logic             out_valid
);

  logic [WIDTH-1:0] y;

  shifter_32_core u_core (
    .X     (X),
    .Sa    (Sa),
    .Arith (Arith),
    .Right (Right),
    .Y     (y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      Sh        <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) Sh <= y;
    end
  end

endmodule

// File: tb/tb_shifter_32.sv
// Scoreboard bench for shifter_32: directed vectors plus a model-checked sweep.
module tb_shifter_32;

  typedef struct {
    logic [31:0] dat;
    int          cyc;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] X;
  logic [4:0]  Sa;
  logic        Arith;
  logic        Right;
  logic        in_valid;
  logic [31:0] Sh;
  logic        out_valid;

  exp_t sb_q[$];
  int   checks  = 0;
  int   errors  = 0;
  int   cyc     = 0;
  int   pushed  = 0;
  int   popped  = 0;

  shifter_32 dut (
    .clk       (clk),
    .rst       (rst),
    .X         (X),
    .Sa        (Sa),
    .Arith     (Arith),
    .Right     (Right),
    .in_valid  (in_valid),
    .Sh        (Sh),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_shift(input logic [31:0] x, input logic [4:0] sa,
                                            input logic ar, input logic rt);
    logic signed [31:0] sx;
    sx = x;
    if (!rt)     return x << sa;
    else if (ar) return sx >>> sa;
    else         return x >> sa;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h", name, act, req);
    end
  endtask

  // Called at posedge+1; operands are captured at the next rising edge.
  task automatic issue(input string name, input logic [31:0] x, input logic [4:0] sa,
                       input logic ar, input logic rt, input logic [31:0] exp_dat);
    exp_t e;
    X = x; Sa = sa; Arith = ar; Right = rt; in_valid = 1'b1;
    e.dat = exp_dat; e.cyc = cyc + 1; e.name = name;
    sb_q.push_back(e);
    pushed++;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Monitor: pops one expectation per valid output and checks data and latency.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: out_valid=1 Sh=%08h with empty scoreboard", Sh);
        end else begin
          e = sb_q.pop_front();
          popped++;
          check(e.name, Sh, e.dat);
          checks++;
          if (cyc != e.cyc) begin
            errors++;
            $display("FAIL %s_latency: result in cycle %0d, expected cycle %0d", e.name, cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] x;
    logic [4:0]  sa;
    logic        ar, rt;

    rst = 1'b1; in_valid = 1'b1; X = 32'hFFFF_FFFF; Sa = 5'd3; Arith = 1'b0; Right = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_sh", Sh, 32'h0);
    check("reset_vld", {31'b0, out_valid}, 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset_vld", {31'b0, out_valid}, 32'h0);

    issue("ar_right_sa4",   32'h8000_0000, 5'd4,  1'b1, 1'b1, 32'hF800_0000);
    issue("lg_right_sa4",   32'h8000_0000, 5'd4,  1'b0, 1'b1, 32'h0800_0000);
    issue("left_sa31_a0",   32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h8000_0000);
    issue("left_sa31_a1",   32'h0000_0001, 5'd31, 1'b1, 1'b0, 32'h8000_0000);
    issue("left_sa8",       32'h0000_000F, 5'd8,  1'b0, 1'b0, 32'h0000_0F00);
    issue("sa0_left",       32'hA5A5_A5A5, 5'd0,  1'b1, 1'b0, 32'hA5A5_A5A5);
    issue("sa0_lg_right",   32'hA5A5_A5A5, 5'd0,  1'b0, 1'b1, 32'hA5A5_A5A5);
    issue("sa0_ar_right",   32'hA5A5_A5A5, 5'd0,  1'b1, 1'b1, 32'hA5A5_A5A5);
    issue("ar_right_sa31",  32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF);
    issue("lg_right_sa31",  32'h8000_0000, 5'd31, 1'b0, 1'b1, 32'h0000_0001);
    issue("ar_pos_sa31",    32'h7FFF_FFFF, 5'd31, 1'b1, 1'b1, 32'h0000_0000);
    idle_cycle();

    issue("b2b_left",       32'h1234_5678, 5'd4,  1'b0, 1'b0, 32'h2345_6780);
    issue("b2b_lg_right",   32'h1234_5678, 5'd4,  1'b0, 1'b1, 32'h0123_4567);
    issue("b2b_ar_right",   32'hF000_0000, 5'd28, 1'b1, 1'b1, 32'hFFFF_FFFF);
    idle_cycle();
    check("hold_vld", {31'b0, out_valid}, 32'h0);
    check("hold_sh", Sh, 32'hFFFF_FFFF);
    idle_cycle();
    check("hold_sh_2", Sh, 32'hFFFF_FFFF);

    // Operands issued while rst is high must never produce a result.
    rst = 1'b1; in_valid = 1'b1; X = 32'h0000_00FF; Sa = 5'd4; Arith = 1'b0; Right = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("rst_drop_sh", Sh, 32'h0);
    check("rst_drop_vld", {31'b0, out_valid}, 32'h0);
    idle_cycle();

    for (int j = 0; j < 1000; j++) begin
      x  = j;
      sa = 5'((3 * j + 5) % 32);
      ar = 1'(j % 2);
      rt = 1'(((2 * j + 1) % 23) % 2);
      issue("sweep", x, sa, ar, rt, ref_shift(x, sa, ar, rt));
    end
    idle_cycle();
    idle_cycle();

    checks++;
    if (sb_q.size() != 0 || popped != pushed) begin
      errors++;
      $display("FAIL drain: %0d results seen, %0d expected", popped, pushed);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
